// File: rtl/matrix_scan_ctrl_pkg.sv
// rtl/matrix_scan_ctrl_pkg.sv - shared types and sizes for the LED matrix scan controller
// Purpose: matrix geometry, row/frame storage types and scan FSM state encoding.
// Ports: none (package).
package matrix_pkg;

  localparam int MATRIX_ROWS = 8;
  localparam int MATRIX_COLS = 8;

  typedef logic [MATRIX_COLS-1:0] row_t;
  typedef row_t [MATRIX_ROWS-1:0] frame_t;

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } scan_state_t;

endpackage

// File: rtl/matrix_scan_ctrl_if.sv
// rtl/matrix_scan_ctrl_if.sv - game-logic / pin-side bundle of the matrix scan controller
// Purpose: groups frame writes, swap handshake, blink tick and scan outputs.
// Ports (master drives -> slave receives):
//   wr_en, wr_plane, wr_row, wr_data : one-row-per-cycle buffer writes (plane 0 = pixels, 1 = blink)
//   swap_req / swap_ack               : request and acknowledge of front := back at frame boundary
//   blink_tick                        : level; each rising edge toggles the blink phase
//   frame_start, row, col             : scan outputs from the controller
interface matrix_scan_ctrl_if;
  import matrix_pkg::*;

  logic       wr_en;
  logic       wr_plane;
  logic [2:0] wr_row;
  row_t       wr_data;
  logic       swap_req;
  logic       swap_ack;
  logic       blink_tick;
  logic       frame_start;
  row_t       row;
  row_t       col;

  modport master (
    output wr_en, wr_plane, wr_row, wr_data, swap_req, blink_tick,
    input  swap_ack, frame_start, row, col
  );

  modport slave (
    input  wr_en, wr_plane, wr_row, wr_data, swap_req, blink_tick,
    output swap_ack, frame_start, row, col
  );

endinterface

// File: rtl/matrix_scan_ctrl.sv
// rtl/matrix_scan_ctrl.sv - double-buffered 8x8 LED row-scan controller with blanking and blink overlay
// Purpose: scans the front buffer row by row (BLANK then ON per row), copies back -> front
//          at the frame boundary on request, and masks blinking pixels by the blink phase.
// Ports:
//   clk  : system clock
//   rst  : synchronous reset, active-high
//   bus  : matrix_scan_ctrl_if.slave (writes, swap handshake, blink tick, row/col/frame_start)
module matrix_scan_ctrl
  import matrix_pkg::*;
#(
  parameter int DWELL_CYCLES = 27000,
  parameter int BLANK_CYCLES = 270
) (
  input logic              clk,
  input logic              rst,
  matrix_scan_ctrl_if.slave bus
);

  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(MATRIX_ROWS);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_ROW   = IDX_W'(MATRIX_ROWS - 1);

  scan_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_row_idx;
  frame_t           r_front;
  frame_t           r_back;
  frame_t           r_blink;
  logic             r_blink_phase;
  logic             r_tick_prev;
  logic             r_swap_pending;
  row_t             r_row;
  row_t             r_col;
  logic             r_swap_ack;
  logic             r_frame_start;

  logic             w_last;
  scan_state_t      w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [IDX_W-1:0] w_row_idx_nxt;
  logic             w_boundary;
  logic             w_copy;
  logic             w_phase_nxt;
  frame_t           w_front_nxt;
  frame_t           w_back_nxt;
  frame_t           w_blink_nxt;
  row_t             w_row_nxt;
  row_t             w_col_nxt;

  assign w_last        = (r_state == BLANK) ? (r_cnt == BLANK_LAST) : (r_cnt == DWELL_LAST);
  assign w_state_nxt   = w_last ? ((r_state == BLANK) ? ON : BLANK) : r_state;
  assign w_cnt_nxt     = w_last ? '0 : r_cnt + 1'b1;
  assign w_row_idx_nxt = (r_state == ON && w_last) ? r_row_idx + 1'b1 : r_row_idx;

  // Frame boundary is the final ON cycle of the last row; a request arriving in
  // that very cycle is honoured here rather than waiting a whole frame.
  assign w_boundary  = (r_state == ON) && w_last && (r_row_idx == LAST_ROW);
  assign w_copy      = w_boundary && (r_swap_pending || bus.swap_req);
  assign w_phase_nxt = r_blink_phase ^ (bus.blink_tick & ~r_tick_prev);

  // Copy reads r_back (pre-write), so a same-cycle write lands only in back.
  assign w_front_nxt = w_copy ? r_back : r_front;

  always_comb begin
    w_back_nxt  = r_back;
    w_blink_nxt = r_blink;
    if (bus.wr_en && !bus.wr_plane) begin
      w_back_nxt[bus.wr_row] = bus.wr_data;
    end
    if (bus.wr_en && bus.wr_plane) begin
      w_blink_nxt[bus.wr_row] = bus.wr_data;
    end
  end

  // Outputs are registered from next-cycle state so row/col always describe
  // the state the scanner is in during that same cycle.
  always_comb begin
    w_row_nxt = '0;
    w_col_nxt = '0;
    if (w_state_nxt == ON) begin
      w_row_nxt = row_t'(1) << w_row_idx_nxt;
      w_col_nxt = w_front_nxt[w_row_idx_nxt] &
                  ~(w_blink_nxt[w_row_idx_nxt] & {MATRIX_COLS{w_phase_nxt}});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= BLANK;
      r_cnt          <= '0;
      r_row_idx      <= '0;
      r_front        <= '0;
      r_back         <= '0;
      r_blink        <= '0;
      r_blink_phase  <= 1'b0;
      r_tick_prev    <= 1'b0;
      r_swap_pending <= 1'b0;
      r_row          <= '0;
      r_col          <= '0;
      r_swap_ack     <= 1'b0;
      r_frame_start  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_row_idx      <= w_row_idx_nxt;
      r_front        <= w_front_nxt;
      r_back         <= w_back_nxt;
      r_blink        <= w_blink_nxt;
      r_blink_phase  <= w_phase_nxt;
      r_tick_prev    <= bus.blink_tick;
      r_swap_pending <= w_copy ? 1'b0 : (r_swap_pending | bus.swap_req);
      r_row          <= w_row_nxt;
      r_col          <= w_col_nxt;
      r_swap_ack     <= w_copy;
      r_frame_start  <= w_boundary;
    end
  end

  assign bus.row         = r_row;
  assign bus.col         = r_col;
  assign bus.swap_ack    = r_swap_ack;
  assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// tb/tb_matrix_scan_ctrl.sv - self-checking bench for matrix_scan_ctrl
module tb_matrix_scan_ctrl;
  import matrix_pkg::*;

  localparam int DW      = 4;
  localparam int BL      = 2;
  localparam int ROW_T   = DW + BL;
  localparam int FRAME_T = 8 * ROW_T;
  localparam int NV      = 160;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  matrix_scan_ctrl_if bus ();

  matrix_scan_ctrl #(
    .DWELL_CYCLES(DW),
    .BLANK_CYCLES(BL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic       rst;
    logic       wr_en;
    logic       wr_plane;
    logic [2:0] wr_row;
    row_t       wr_data;
    logic       swap_req;
    logic       blink_tick;
    row_t       exp_row;
    row_t       exp_col;
    logic       exp_fs;
  } vec_t;

  vec_t vecs[NV];
  int   checks = 0;
  int   errors = 0;
  int   ack_q[$];

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, idx, act, exp);
    end
  endtask

  // Expected scan outputs from the frame layout: each row is BL blank cycles then DW lit cycles.
  task automatic fill(input int i, input int s, input frame_t fr, input frame_t bk, input bit ph);
    int pos;
    int r;
    pos = s % FRAME_T;
    r   = pos / ROW_T;
    vecs[i].rst        = 1'b0;
    vecs[i].wr_en      = 1'b0;
    vecs[i].wr_plane   = 1'b0;
    vecs[i].wr_row     = 3'd0;
    vecs[i].wr_data    = 8'h00;
    vecs[i].swap_req   = 1'b0;
    vecs[i].blink_tick = 1'b0;
    if ((pos % ROW_T) < BL) begin
      vecs[i].exp_row = 8'h00;
      vecs[i].exp_col = 8'h00;
    end else begin
      vecs[i].exp_row = 8'(1 << r);
      vecs[i].exp_col = fr[r] & ~(bk[r] & {8{ph}});
    end
    vecs[i].exp_fs = (s >= FRAME_T) && (pos == 0);
  endtask

  task automatic set_wr(input int i, input logic plane, input logic [2:0] r, input row_t d);
    vecs[i].wr_en    = 1'b1;
    vecs[i].wr_plane = plane;
    vecs[i].wr_row   = r;
    vecs[i].wr_data  = d;
  endtask

  task automatic idle_inputs();
    bus.wr_en      = 1'b0;
    bus.wr_plane   = 1'b0;
    bus.wr_row     = 3'd0;
    bus.wr_data    = 8'h00;
    bus.swap_req   = 1'b0;
    bus.blink_tick = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    ack_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Each iteration: sample the current cycle, then drive this cycle's inputs.
  // Swap requests push the index where the ack must appear (cycle after the next boundary).
  task automatic run(input int n);
    int   s;
    int   ack_idx;
    logic exp_ack;
    s = 0;
    for (int i = 0; i < n; i++) begin
      chk("row", i, bus.row, vecs[i].exp_row);
      chk("col", i, bus.col, vecs[i].exp_col);
      chk("frame_start", i, {7'b0, bus.frame_start}, {7'b0, vecs[i].exp_fs});
      exp_ack = (ack_q.size() > 0) && (ack_q[0] == i);
      chk("swap_ack", i, {7'b0, bus.swap_ack}, {7'b0, exp_ack});
      if (exp_ack) void'(ack_q.pop_front());

      rst            = vecs[i].rst;
      bus.wr_en      = vecs[i].wr_en;
      bus.wr_plane   = vecs[i].wr_plane;
      bus.wr_row     = vecs[i].wr_row;
      bus.wr_data    = vecs[i].wr_data;
      bus.swap_req   = vecs[i].swap_req;
      bus.blink_tick = vecs[i].blink_tick;

      if (vecs[i].swap_req) begin
        ack_idx = i + (FRAME_T - 1 - (s % FRAME_T)) + 1;
        if (ack_q.size() == 0 || ack_q[$] != ack_idx) ack_q.push_back(ack_idx);
      end
      if (vecs[i].rst) begin
        ack_q.delete();
        s = 0;
      end else begin
        s++;
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    idle_inputs();
    chk("ack_queue_drained", n, 8'(ack_q.size()), 8'h00);
  endtask

  task automatic test_idle();
    frame_t z;
    z = '0;
    for (int i = 0; i < 100; i++) fill(i, i, z, z, 1'b0);
    do_reset();
    run(100);
  endtask

  task automatic test_swap_basic();
    frame_t z;
    frame_t f1;
    z = '0;
    f1 = '0;
    f1[3] = 8'hA5;
    for (int i = 0; i < 100; i++) fill(i, i, (i >= FRAME_T) ? f1 : z, z, 1'b0);
    set_wr(3, 1'b0, 3'd3, 8'hA5);
    vecs[10].swap_req = 1'b1;
    do_reset();
    run(100);
  endtask

  task automatic test_swap_absorb();
    frame_t z;
    frame_t f2;
    z = '0;
    f2 = '0;
    f2[0] = 8'hFF;
    for (int i = 0; i < 110; i++) fill(i, i, (i >= 2 * FRAME_T) ? f2 : z, z, 1'b0);
    vecs[5].swap_req  = 1'b1;
    vecs[20].swap_req = 1'b1;
    set_wr(FRAME_T - 1, 1'b0, 3'd0, 8'hFF);
    vecs[2 * FRAME_T - 1].swap_req = 1'b1;
    do_reset();
    run(110);
  endtask

  task automatic test_blink();
    frame_t z;
    frame_t f1;
    frame_t b1;
    bit     ph;
    z = '0;
    f1 = '0;
    f1[2] = 8'hF0;
    b1 = '0;
    b1[2] = 8'h30;
    for (int i = 0; i < 120; i++) begin
      ph = (i >= 63) && (i <= 111);
      fill(i, i, (i >= FRAME_T) ? f1 : z, (i >= 3) ? b1 : z, ph);
      vecs[i].blink_tick = ((i >= 62) && (i <= 100)) || (i >= 111);
    end
    set_wr(1, 1'b0, 3'd2, 8'hF0);
    set_wr(2, 1'b1, 3'd2, 8'h30);
    vecs[3].swap_req = 1'b1;
    do_reset();
    run(120);
  endtask

  task automatic test_reset_mid();
    frame_t z;
    z = '0;
    for (int i = 0; i < 134; i++) fill(i, (i < 34) ? i : i - 34, z, z, 1'b0);
    set_wr(1, 1'b0, 3'd5, 8'h3C);
    vecs[2].swap_req = 1'b1;
    vecs[33].rst = 1'b1;
    do_reset();
    run(134);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_idle();
    test_swap_basic();
    test_swap_absorb();
    test_blink();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
